ungapped_extend_engine: RTL and testbench

//  Parametrised ungapped seed-extension engine, the successor to the fixed 512-symbol expand FSM.

---
 rtl/ungapped_extend_engine.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ungapped_extend_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ungapped_extend_engine.sv
// Ungapped seed-extension engine: fetches up to three DB blocks around a seed hit, X-drop extends both
// directions in parallel and reports best score and DB span. Optional build macro: SCORE_THRESH_EN.
module ungapped_extend_engine #(
  parameter int SYM_BITS   = 2,
  parameter int BLK_SYMS   = 512,
  parameter int QUERY_SYMS = 512,
  parameter int SEED_LEN   = 22,
  parameter int MAX_EXT    = 200,
  parameter int MATCH      = 1,
  parameter int MISMATCH   = 3,
  parameter int XDROP      = 10,
  parameter int SCORE_W    = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           queryValid,
  input  logic [QUERY_SYMS*SYM_BITS-1:0] inQuery,
  input  logic [16:0]                    dbBlocks,
  input  logic [SCORE_W-1:0]             minScore,
  input  logic                           hitValid,
  output logic                           hitReady,
  input  logic [$clog2(QUERY_SYMS)-1:0]  hitQPos,
  input  logic [31:0]                    hitDbPos,
  output logic                           load,
  output logic [31:0]                    outAddress,
  input  logic                           loadDone,
  input  logic                           dataValid,
  input  logic [BLK_SYMS*SYM_BITS-1:0]   inDB,
  output logic                           resValid,
  input  logic                           resReady,
  output logic [SCORE_W-1:0]             Score,
  output logic [31:0]                    highestLocationStart,
  output logic [31:0]                    highestLocationEnd,
  output logic                           busy,
  output logic [2:0]                     dbgState
);
  localparam int OFF_W    = $clog2(BLK_SYMS);
  localparam int WIN_SYMS = 3 * BLK_SYMS;
  localparam int PTR_W    = $clog2(WIN_SYMS) + 1;
  localparam int QP_W     = $clog2(QUERY_SYMS + SEED_LEN + MAX_EXT + 1);
  localparam int K_W      = $clog2(MAX_EXT + 2);
  localparam int SW       = SCORE_W + 2;
  localparam logic signed [SW-1:0] SMAX_W = SW'(2 ** (SCORE_W - 1) - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_C = 3'd1,
    FETCH_L = 3'd2,
    FETCH_R = 3'd3,
    EXTEND  = 3'd4,
    REPORT  = 3'd5
  } state_t;

  state_t                         state;
  logic [QUERY_SYMS*SYM_BITS-1:0] queryR;
  logic [BLK_SYMS*SYM_BITS-1:0]   winL, winC, winR;
  logic [WIN_SYMS*SYM_BITS-1:0]   win;
  logic [31:0]                    dbPosR, blkBase, addrR, startR, endR;
  logic                           needL, needR, haveL, haveR, pending;
  logic                           loadR, hitReadyR, busyR, resValidR;
  logic signed [SCORE_W-1:0]      scoreR;
  logic [K_W-1:0]                 k, lenL, lenR;
  logic                           stopL, stopR;
  logic signed [SCORE_W-1:0]      runL, runR, bestL, bestR;
  logic [PTR_W-1:0]               lPtr, rPtr;
  logic [QP_W-1:0]                lQ, rQ;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high; a valid
  // source holds its payload until then (hit, result). load is a request held until loadDone.
  assign hitReady             = hitReadyR;
  assign busy                 = busyR;
  assign load                 = loadR;
  assign outAddress           = addrR;
  assign resValid             = resValidR;
  assign Score                = scoreR;
  assign highestLocationStart = startR;
  assign highestLocationEnd   = endR;
  assign dbgState             = state;

  logic unusedMinScore;
  assign unusedMinScore = ^minScore;

  function automatic logic signed [SCORE_W-1:0] stepScore(input logic signed [SCORE_W-1:0] r,
                                                          input logic hit);
    logic signed [SW-1:0] w;
    w = SW'(r);
    if (hit) w = w + SW'(MATCH);
    else     w = w - SW'(MISMATCH);
    if (w > SMAX_W)       w = SMAX_W;
    else if (w < -SMAX_W) w = -SMAX_W;
    return SCORE_W'(w);
  endfunction

  // Hit decode: blocks are power-of-two sized, so block/offset are a bit split of the DB position.
  logic [OFF_W-1:0] hitOff;
  logic [31:0]      hitBlk;
  logic             needLNext, needRNext;
  assign hitOff    = hitDbPos[OFF_W-1:0];
  assign hitBlk    = hitDbPos >> OFF_W;
  assign needLNext = (hitBlk != 32'd0) && (32'(hitOff) < 32'(MAX_EXT));
  assign needRNext = ((hitBlk + 32'd1) < 32'(dbBlocks)) &&
                     ((32'(hitOff) + 32'(SEED_LEN + MAX_EXT)) > 32'(BLK_SYMS));

  // Window symbol w lives in winL for w<BLK_SYMS, winC next, winR last.
  assign win = {winR, winC, winL};

  logic [QP_W-1:0]           qIdxL, qIdxR;
  logic                      edgeL, edgeR, capK, absentL, absentR, haltL, haltR;
  logic [SYM_BITS-1:0]       qSymL, qSymR, dSymL, dSymR;
  logic signed [SCORE_W-1:0] nRunL, nRunR, nBestL, nBestR, scoreSum;
  logic                      improveL, improveR, dropL, dropR;
  logic signed [SW-1:0]      scoreWide;

  assign edgeL   = (lQ == '0);
  assign edgeR   = (rQ >= QP_W'(QUERY_SYMS));
  assign capK    = (k == K_W'(MAX_EXT));
  assign absentL = (lPtr < PTR_W'(BLK_SYMS)) && !haveL;
  assign absentR = ((rPtr >= PTR_W'(2 * BLK_SYMS)) && !haveR) || (rPtr >= PTR_W'(WIN_SYMS));
  assign haltL   = capK || edgeL || absentL;
  assign haltR   = capK || edgeR || absentR;
  assign qIdxL   = edgeL ? '0 : lQ - QP_W'(1);
  assign qIdxR   = edgeR ? '0 : rQ;
  assign qSymL   = queryR[int'(qIdxL)*SYM_BITS +: SYM_BITS];
  assign qSymR   = queryR[int'(qIdxR)*SYM_BITS +: SYM_BITS];
  assign dSymL   = win[int'(lPtr)*SYM_BITS +: SYM_BITS];
  assign dSymR   = win[int'(rPtr)*SYM_BITS +: SYM_BITS];

  assign nRunL    = stepScore(runL, qSymL == dSymL);
  assign nRunR    = stepScore(runR, qSymR == dSymR);
  assign improveL = nRunL > bestL;
  assign improveR = nRunR > bestR;
  assign nBestL   = improveL ? nRunL : bestL;
  assign nBestR   = improveR ? nRunR : bestR;
  assign dropL    = (SW'(nBestL) - SW'(nRunL)) > SW'(XDROP);
  assign dropR    = (SW'(nBestR) - SW'(nRunR)) > SW'(XDROP);

  // Both bests are non-negative, so only the positive limit can be reached.
  always_comb begin
    scoreWide = SW'(SEED_LEN * MATCH) + SW'(bestL) + SW'(bestR);
    if (scoreWide > SMAX_W) scoreWide = SMAX_W;
    scoreSum = SCORE_W'(scoreWide);
  end

  always_ff @(posedge clk) begin
    if (pending && dataValid) begin
      case (state)
        FETCH_L: winL <= inDB;
        FETCH_C: winC <= inDB;
        FETCH_R: winR <= inDB;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      queryR    <= '0;
      dbPosR    <= '0;
      blkBase   <= '0;
      addrR     <= '0;
      startR    <= '0;
      endR      <= '0;
      scoreR    <= '0;
      needL     <= 1'b0;
      needR     <= 1'b0;
      haveL     <= 1'b0;
      haveR     <= 1'b0;
      pending   <= 1'b0;
      loadR     <= 1'b0;
      hitReadyR <= 1'b1;
      busyR     <= 1'b0;
      resValidR <= 1'b0;
      k         <= '0;
      lenL      <= '0;
      lenR      <= '0;
      stopL     <= 1'b0;
      stopR     <= 1'b0;
      runL      <= '0;
      runR      <= '0;
      bestL     <= '0;
      bestR     <= '0;
      lPtr      <= '0;
      rPtr      <= '0;
      lQ        <= '0;
      rQ        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (queryValid) queryR <= inQuery;
          if (hitValid && hitReadyR) begin
            dbPosR    <= hitDbPos;
            blkBase   <= {hitDbPos[31:OFF_W], {OFF_W{1'b0}}};
            addrR     <= {hitDbPos[31:OFF_W], {OFF_W{1'b0}}};
            needL     <= needLNext;
            needR     <= needRNext;
            haveL     <= 1'b0;
            haveR     <= 1'b0;
            pending   <= 1'b0;
            loadR     <= 1'b1;
            hitReadyR <= 1'b0;
            busyR     <= 1'b1;
            k         <= '0;
            lenL      <= '0;
            lenR      <= '0;
            stopL     <= 1'b0;
            stopR     <= 1'b0;
            runL      <= '0;
            runR      <= '0;
            bestL     <= '0;
            bestR     <= '0;
            lPtr      <= PTR_W'(BLK_SYMS + int'(hitOff) - 1);
            rPtr      <= PTR_W'(BLK_SYMS + int'(hitOff) + SEED_LEN);
            lQ        <= QP_W'(hitQPos);
            rQ        <= QP_W'(hitQPos) + QP_W'(SEED_LEN);
            state     <= FETCH_C;
          end
        end
        FETCH_C, FETCH_L, FETCH_R: begin
          if (loadR && loadDone) begin
            loadR   <= 1'b0;
            pending <= 1'b1;
          end else if (pending && dataValid) begin
            pending <= 1'b0;
            if (state == FETCH_L) haveL <= 1'b1;
            if (state == FETCH_R) haveR <= 1'b1;
            if (state == FETCH_C && needL) begin
              state <= FETCH_L;
              loadR <= 1'b1;
              addrR <= blkBase - 32'(BLK_SYMS);
            end else if (state != FETCH_R && needR) begin
              state <= FETCH_R;
              loadR <= 1'b1;
              addrR <= blkBase + 32'(BLK_SYMS);
            end else begin
              state <= EXTEND;
            end
          end
        end
        EXTEND: begin
          if (stopL && stopR) begin
            scoreR <= scoreSum;
            startR <= dbPosR - 32'(lenL);
            endR   <= dbPosR + 32'(SEED_LEN - 1) + 32'(lenR);
`ifdef SCORE_THRESH_EN
            if (scoreSum < $signed(minScore)) begin
              state     <= IDLE;
              hitReadyR <= 1'b1;
              busyR     <= 1'b0;
            end else begin
              state     <= REPORT;
              resValidR <= 1'b1;
            end
`else
            state     <= REPORT;
            resValidR <= 1'b1;
`endif
          end else begin
            k <= k + K_W'(1);
            if (!stopL) begin
              if (haltL) begin
                stopL <= 1'b1;
              end else begin
                runL  <= nRunL;
                bestL <= nBestL;
                if (improveL) lenL <= k + K_W'(1);
                if (dropL) stopL <= 1'b1;
                lPtr <= lPtr - PTR_W'(1);
                lQ   <= lQ - QP_W'(1);
              end
            end
            if (!stopR) begin
              if (haltR) begin
                stopR <= 1'b1;
              end else begin
                runR  <= nRunR;
                bestR <= nBestR;
                if (improveR) lenR <= k + K_W'(1);
                if (dropR) stopR <= 1'b1;
                rPtr <= rPtr + PTR_W'(1);
                rQ   <= rQ + QP_W'(1);
              end
            end
          end
        end
        REPORT: begin
          if (resReady) begin
            resValidR <= 1'b0;
            hitReadyR <= 1'b1;
            busyR     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ungapped_extend_engine.sv
// Directed scoreboard bench for ungapped_extend_engine: expected results and fetch addresses are
// queued at issue time and checked by a result monitor and the loader model.
module tb_ungapped_extend_engine;
  localparam int EXTEND_ST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          queryValid;
  logic [1023:0] inQuery;
  logic [16:0]   dbBlocks;
  logic [11:0]   minScore;
  logic          hitValid;
  logic          hitReady;
  logic [8:0]    hitQPos;
  logic [31:0]   hitDbPos;
  logic          load;
  logic [31:0]   outAddress;
  logic          loadDone;
  logic          dataValid;
  logic [1023:0] inDB;
  logic          resValid;
  logic          resReady;
  logic [11:0]   Score;
  logic [31:0]   highestLocationStart;
  logic [31:0]   highestLocationEnd;
  logic          busy;
  logic [2:0]    dbgState;

  ungapped_extend_engine dut (
    .clk(clk), .rst(rst), .queryValid(queryValid), .inQuery(inQuery), .dbBlocks(dbBlocks),
    .minScore(minScore), .hitValid(hitValid), .hitReady(hitReady), .hitQPos(hitQPos),
    .hitDbPos(hitDbPos), .load(load), .outAddress(outAddress), .loadDone(loadDone),
    .dataValid(dataValid), .inDB(inDB), .resValid(resValid), .resReady(resReady),
    .Score(Score), .highestLocationStart(highestLocationStart),
    .highestLocationEnd(highestLocationEnd), .busy(busy), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  logic [1:0]  qMem [0:511];
  logic [1:0]  dbMem[0:1535];
  logic [75:0] exp_q[$];
  logic [31:0] expAddr_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Loader model: one-cycle accept, data on the following cycle.
  initial begin
    int          phase;
    logic [31:0] addr;
    phase = 0;
    addr = '0;
    loadDone = 1'b0;
    dataValid = 1'b0;
    inDB = '0;
    forever begin
      @(posedge clk); #1;
      loadDone = 1'b0;
      dataValid = 1'b0;
      if (phase == 1) begin
        for (int s = 0; s < 512; s++) inDB[s*2 +: 2] = dbMem[(int'(addr) + s) % 1536];
        dataValid = 1'b1;
        phase = 0;
      end else if (load && rst) begin
        addr = outAddress;
        if (expAddr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch actual=%0d expected=none", addr);
        end else begin
          chk("fetch_addr", addr, expAddr_q.pop_front());
        end
        loadDone = 1'b1;
        phase = 1;
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst && resValid && resReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d expected=none", Score);
      end else begin
        logic [75:0] e;
        e = exp_q.pop_front();
        chk("score", 32'(Score), 32'(e[75:64]));
        chk("loc_start", highestLocationStart, e[63:32]);
        chk("loc_end", highestLocationEnd, e[31:0]);
      end
    end
  end

  task automatic setDb(input int shift);
    for (int j = 0; j < 1536; j++) dbMem[j] = qMem[((j - shift) % 512 + 512) % 512];
  endtask

  task automatic flipDb(input int j);
    dbMem[j] = dbMem[j] ^ 2'b01;
  endtask

  task automatic loadQuery();
    @(posedge clk); #1;
    for (int i = 0; i < 512; i++) inQuery[i*2 +: 2] = qMem[i];
    queryValid = 1'b1;
    @(posedge clk); #1;
    queryValid = 1'b0;
  endtask

  task automatic issueHit(input int q, input int db, input int blocks);
    @(posedge clk); #1;
    dbBlocks = 17'(blocks);
    hitQPos = 9'(q);
    hitDbPos = 32'(db);
    hitValid = 1'b1;
    @(posedge clk); #1;
    hitValid = 1'b0;
    chk("hit_accepted_busy", 32'(busy), 32'd1);
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy expected=idle", name);
    end
  endtask

  task automatic runCase(input string name, input int q, input int db, input int blocks,
                         input int score, input int lStart, input int lEnd);
    exp_q.push_back({12'(score), 32'(lStart), 32'(lEnd)});
    issueHit(q, db, blocks);
    waitIdle(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b0;
    queryValid = 1'b0;
    inQuery = '0;
    dbBlocks = 17'd1;
    minScore = '0;
    hitValid = 1'b0;
    hitQPos = '0;
    hitDbPos = '0;
    resReady = 1'b1;
    for (int i = 0; i < 512; i++) qMem[i] = 2'((i * 5 + (i >> 2) * 3 + (i >> 5)) & 3);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_hitReady", 32'(hitReady), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_resValid", 32'(resValid), 32'd0);
    chk("rst_score", 32'(Score), 32'd0);
    chk("rst_start", highestLocationStart, 32'd0);
    chk("rst_end", highestLocationEnd, 32'd0);
    chk("rst_outAddress", outAddress, 32'd0);

    loadQuery();

    // Identical query/DB, single block: left to query edge, right to MAX_EXT.
    setDb(0);
    expAddr_q.push_back(32'd0);
    runCase("identical", 100, 100, 1, 322, 0, 321);

    // Centre block 1 then left block 0; left extension crosses into block 0.
    setDb(462);
    expAddr_q.push_back(32'd512);
    expAddr_q.push_back(32'd0);
    runCase("fetch_left", 100, 562, 3, 322, 462, 783);

    // Four left mismatches: X-drop after k=3, left contributes nothing.
    setDb(0);
    for (int j = 96; j < 100; j++) flipDb(j);
    expAddr_q.push_back(32'd0);
    runCase("left_xdrop", 100, 100, 1, 222, 100, 321);

    // Left dead at qPos=0; right 5 match, 1 mismatch, 20 match, then mismatches.
    setDb(0);
    flipDb(27);
    for (int j = 48; j < 52; j++) flipDb(j);
    expAddr_q.push_back(32'd0);
    runCase("right_26", 0, 0, 1, 44, 0, 47);

    // Right block fetch; right extension hits the query end at k=190.
    setDb(100);
    expAddr_q.push_back(32'd0);
    expAddr_q.push_back(32'd512);
    runCase("fetch_right", 300, 400, 2, 412, 200, 611);

    // Seed ends at the query end: right stops immediately.
    setDb(0);
    expAddr_q.push_back(32'd0);
    runCase("query_end", 490, 490, 1, 222, 290, 511);

    // Result backpressure for 10 cycles.
    setDb(0);
    resReady = 1'b0;
    expAddr_q.push_back(32'd0);
    exp_q.push_back({12'd422, 32'd0, 32'd421});
    issueHit(200, 200, 1);
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (resValid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_result_seen", 32'(seen), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_resValid", 32'(resValid), 32'd1);
      chk("bp_score", 32'(Score), 32'd422);
      chk("bp_end", highestLocationEnd, 32'd421);
      chk("bp_hitReady", 32'(hitReady), 32'd0);
    end
    resReady = 1'b1;
    waitIdle("backpressure");

    // Reset in the middle of EXTEND aborts silently.
    setDb(0);
    expAddr_q.push_back(32'd0);
    issueHit(100, 100, 1);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (dbgState == 3'(EXTEND_ST)) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_reached_extend", 32'(seen), 32'd1);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_load", 32'(load), 32'd0);
    chk("abort_resValid", 32'(resValid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_hitReady", 32'(hitReady), 32'd1);
    chk("abort_score_cleared", 32'(Score), 32'd0);
    loadQuery();
    setDb(0);
    flipDb(27);
    for (int j = 48; j < 52; j++) flipDb(j);
    expAddr_q.push_back(32'd0);
    runCase("after_abort", 0, 0, 1, 44, 0, 47);

    repeat (5) @(posedge clk);
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    chk("fetches_drained", 32'(expAddr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
